// File: rtl/gps_display_sched.sv
`timescale 1ns/1ps
// gps_display_sched: rotating GPS time-of-day LED display with alert preemption and a stale-data flag.
// Build macro GPS_DISP_STALE_BLINK_EN: blank led_out on alternate dwell periods while stale.
module gps_display_sched #(
  parameter int unsigned DWELL_CYCLES = 32'd50000000,
  parameter int unsigned STALE_CYCLES = 32'd100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nsr_valid,
  input  logic [4:0] gps_hr,
  input  logic [5:0] gps_min,
  input  logic [5:0] gps_sec,
  input  logic       mode_auto,
  input  logic [1:0] manual_sel,
  input  logic       alert_req,
  input  logic [7:0] alert_code,
  output logic [7:0] led_out,
  output logic [1:0] field_id,
  output logic       alert_ack,
  output logic       stale
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int SW = $clog2(STALE_CYCLES + 32'd1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 32'd1);
  localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_CYCLES);
  localparam logic [SW-1:0] STALE_PRE  = SW'(STALE_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    NOFIX    = 3'd0,
    SHOW_HR  = 3'd1,
    SHOW_MIN = 3'd2,
    SHOW_SEC = 3'd3,
    ALERT    = 3'd4
  } state_t;

  state_t          state_q, ret_q;
  state_t          sel_state_d, next_state_d, ret_d;
  logic [DW-1:0]   dwell_q;
  logic [SW-1:0]   stale_cnt_q;
  logic            stale_q, ack_q, block_q, mode_q;
  logic [4:0]      hr_q;
  logic [5:0]      min_q, sec_q;
  logic [7:0]      code_q, led_q, led_d, raw_led_s;
  logic [1:0]      field_q, field_d, show_s, disp_sel_s;
  logic            blank_s;

`ifdef GPS_DISP_STALE_BLINK_EN
  logic [DW-1:0]   blink_cnt_q;
  logic            blink_q;

  // Blink phase flips once per dwell period while the data is stale.
  always_ff @(posedge clk) begin
    if (rst || !stale_q) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == DWELL_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blank_s = stale_q && blink_q && (state_q != ALERT);
`else
  assign blank_s = 1'b0;
`endif

  // Next-field selection and the display value registered on the following edge.
  always_comb begin
    sel_state_d  = SHOW_HR;
    next_state_d = SHOW_HR;
    show_s       = 2'd0;
    raw_led_s    = 8'h00;
    field_d      = 2'd3;
    case (manual_sel)
      2'd1:    sel_state_d = SHOW_MIN;
      2'd2:    sel_state_d = SHOW_SEC;
      default: sel_state_d = SHOW_HR;
    endcase
    case (state_q)
      SHOW_HR:  begin next_state_d = SHOW_MIN; show_s = 2'd0; end
      SHOW_MIN: begin next_state_d = SHOW_SEC; show_s = 2'd1; end
      default:  begin next_state_d = SHOW_HR;  show_s = 2'd2; end
    endcase
    // A pending return to NOFIX becomes SHOW_HR once a sentence has arrived.
    ret_d      = (nsr_valid && ret_q == NOFIX) ? SHOW_HR : ret_q;
    disp_sel_s = mode_auto ? show_s : manual_sel;
    case (state_q)
      SHOW_HR, SHOW_MIN, SHOW_SEC: begin
        field_d = disp_sel_s;
        case (disp_sel_s)
          2'd0:    raw_led_s = {3'b000, hr_q};
          2'd1:    raw_led_s = {2'b00, min_q};
          2'd2:    raw_led_s = {2'b00, sec_q};
          default: raw_led_s = 8'h66;
        endcase
      end
      ALERT:   begin raw_led_s = code_q; field_d = 2'd3; end
      default: begin raw_led_s = 8'h00;  field_d = 2'd3; end
    endcase
    led_d = blank_s ? 8'h00 : raw_led_s;
  end

  // Scheduler FSM, snapshot, staleness tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NOFIX;
      ret_q       <= NOFIX;
      dwell_q     <= '0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
      hr_q        <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      code_q      <= 8'h00;
      led_q       <= 8'h00;
      field_q     <= 2'd3;
      ack_q       <= 1'b0;
      block_q     <= 1'b0;
      mode_q      <= 1'b1;
    end else begin
      led_q   <= led_d;
      field_q <= field_d;
      ack_q   <= 1'b0;
      mode_q  <= mode_auto;
      if (nsr_valid) begin
        hr_q        <= gps_hr;
        min_q       <= gps_min;
        sec_q       <= gps_sec;
        stale_cnt_q <= '0;
        stale_q     <= 1'b0;
      end else if (stale_cnt_q != STALE_MAX) begin
        stale_cnt_q <= stale_cnt_q + 1'b1;
        stale_q     <= (stale_cnt_q == STALE_PRE);
      end else begin
        stale_q     <= 1'b1;
      end
      case (state_q)
        NOFIX: begin
          block_q <= 1'b0;
          if (alert_req && !block_q) begin
            ack_q   <= 1'b1;
            code_q  <= alert_code;
            ret_q   <= nsr_valid ? (mode_auto ? SHOW_HR : sel_state_d) : NOFIX;
            state_q <= ALERT;
            dwell_q <= '0;
          end else if (nsr_valid) begin
            state_q <= mode_auto ? SHOW_HR : sel_state_d;
            dwell_q <= '0;
          end
        end
        ALERT: begin
          ret_q <= ret_d;
          if (dwell_q == DWELL_LAST) begin
            state_q <= ret_d;
            dwell_q <= '0;
            block_q <= 1'b1;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        SHOW_HR, SHOW_MIN, SHOW_SEC: begin
          block_q <= 1'b0;
          if (alert_req && !block_q) begin
            ack_q   <= 1'b1;
            code_q  <= alert_code;
            ret_q   <= state_q;
            state_q <= ALERT;
            dwell_q <= '0;
          end else if (!mode_auto) begin
            state_q <= sel_state_d;
            dwell_q <= '0;
          end else if (mode_auto != mode_q) begin
            dwell_q <= '0;
          end else if (!stale_q) begin
            if (dwell_q == DWELL_LAST) begin
              state_q <= next_state_d;
              dwell_q <= '0;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= NOFIX;
          dwell_q <= '0;
        end
      endcase
    end
  end

  assign led_out   = led_q;
  assign field_id  = field_q;
  assign alert_ack = ack_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_gps_display_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for gps_display_sched with DWELL_CYCLES=4, STALE_CYCLES=20.
module tb_gps_display_sched;

  logic       clk = 1'b0;
  logic       rst, nsr_valid, mode_auto, alert_req;
  logic [4:0] gps_hr;
  logic [5:0] gps_min, gps_sec;
  logic [1:0] manual_sel, field_id;
  logic [7:0] alert_code, led_out;
  logic       alert_ack, stale;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] fid;
    logic       ack;
    logic       stl;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef GPS_DISP_STALE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  gps_display_sched #(.DWELL_CYCLES(4), .STALE_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .nsr_valid(nsr_valid), .gps_hr(gps_hr), .gps_min(gps_min),
    .gps_sec(gps_sec), .mode_auto(mode_auto), .manual_sel(manual_sel), .alert_req(alert_req),
    .alert_code(alert_code), .led_out(led_out), .field_id(field_id), .alert_ack(alert_ack),
    .stale(stale)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] l, input logic [1:0] f, input logic a, input logic s);
    mk = {l, f, a, s};
  endfunction

  task automatic do_reset();
    rst = 1'b1; nsr_valid = 1'b0; alert_req = 1'b0; alert_code = 8'h00;
    mode_auto = 1'b1; manual_sel = 2'd0;
    gps_hr = 5'd10; gps_min = 6'd25; gps_sec = 6'd59;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL reset_led: got %02h expected 00", led_out); end
    n_cmp++; if (field_id !== 2'd3) begin n_err++; $display("FAIL reset_fid: got %0d expected 3", field_id); end
    n_cmp++; if (alert_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0b expected 0", alert_ack); end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL reset_stale: got %0b expected 0", stale); end
  endtask

  task automatic test_auto();
    exp_t e, o;
    do_reset();
    sb_q.push_back(mk(8'h00, 2'd3, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++)  sb_q.push_back(mk(8'h0A, 2'd0, 1'b0, 1'b0));
    for (int k = 5; k <= 8; k++)  sb_q.push_back(mk(8'h19, 2'd1, 1'b0, 1'b0));
    for (int k = 9; k <= 12; k++) sb_q.push_back(mk(8'h3B, 2'd2, 1'b0, 1'b0));
    sb_q.push_back(mk(8'h0A, 2'd0, 1'b0, 1'b0));
    nsr_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL auto k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0) nsr_valid = 1'b0;
    end
  endtask

  task automatic test_manual();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 28; k++) begin
      if (k == 0)       e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      else if (k == 1)  e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else if (k <= 21) e = mk(8'h66, 2'd3, 1'b0, 1'b0);
      else if (k <= 26) e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else              e = mk(8'h19, 2'd1, 1'b0, 1'b0);
      e.stl = (k == 20 || k == 21);
      sb_q.push_back(e);
    end
    nsr_valid = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL manual k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0)  nsr_valid = 1'b0;
      if (k == 1)  begin mode_auto = 1'b0; manual_sel = 2'd3; end
      if (k == 21) begin mode_auto = 1'b1; nsr_valid = 1'b1; end
      if (k == 22) nsr_valid = 1'b0;
    end
  endtask

  task automatic test_alert();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 0)       e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      else if (k <= 4)  e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else if (k <= 6)  e = mk(8'h19, 2'd1, k == 6, 1'b0);
      else if (k <= 10) e = mk(8'hA5, 2'd3, 1'b0, 1'b0);
      else if (k <= 14) e = mk(8'h19, 2'd1, 1'b0, 1'b0);
      else              e = mk(8'h3B, 2'd2, 1'b0, 1'b0);
      sb_q.push_back(e);
    end
    nsr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL alert k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0) nsr_valid = 1'b0;
      if (k == 5) begin alert_req = 1'b1; alert_code = 8'hA5; end
      if (k == 6) alert_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      if (k == 0)       e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      else if (k == 1)  e = mk(8'h0A, 2'd0, 1'b1, 1'b0);
      else if (k <= 5)  e = mk(8'hC3, 2'd3, 1'b0, 1'b0);
      else if (k <= 7)  e = mk(8'h0A, 2'd0, k == 7, 1'b0);
      else if (k <= 11) e = mk(8'hC3, 2'd3, 1'b0, 1'b0);
      else if (k <= 15) e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else              e = mk(8'h19, 2'd1, 1'b0, 1'b0);
      sb_q.push_back(e);
    end
    nsr_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0) begin nsr_valid = 1'b0; alert_req = 1'b1; alert_code = 8'hC3; end
      if (k == 7) alert_req = 1'b0;
    end
  endtask

  task automatic test_stale();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 39; k++) begin
      if (k == 0)       e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      else if (k <= 4)  e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else if (k <= 8)  e = mk(8'h19, 2'd1, 1'b0, 1'b0);
      else if (k <= 12) e = mk(8'h3B, 2'd2, 1'b0, 1'b0);
      else if (k <= 16) e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else if (k <= 20) e = mk(8'h19, 2'd1, 1'b0, 1'b0);
      else if (k <= 37) e = mk(8'h3B, 2'd2, 1'b0, 1'b0);
      else              e = mk(8'h07, 2'd2, 1'b0, 1'b0);
      e.stl = (k >= 20 && k <= 36);
      if (BLINK && ((k >= 25 && k <= 28) || (k >= 33 && k <= 36))) e.led = 8'h00;
      sb_q.push_back(e);
    end
    nsr_valid = 1'b1;
    for (int k = 0; k < 39; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stale k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0)  nsr_valid = 1'b0;
      if (k == 36) begin nsr_valid = 1'b1; gps_sec = 6'd7; end
      if (k == 37) nsr_valid = 1'b0;
    end
  endtask

  task automatic test_reset_alert();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k == 0)      e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      else if (k <= 2) e = mk(8'h0A, 2'd0, k == 2, 1'b0);
      else if (k <= 4) e = mk(8'h3C, 2'd3, 1'b0, 1'b0);
      else             e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      sb_q.push_back(e);
    end
    nsr_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_alert k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0) nsr_valid = 1'b0;
      if (k == 1) begin alert_req = 1'b1; alert_code = 8'h3C; end
      if (k == 2) alert_req = 1'b0;
      if (k == 4) begin rst = 1'b1; nsr_valid = 1'b1; alert_req = 1'b1; end
      if (k == 5) begin rst = 1'b0; nsr_valid = 1'b0; alert_req = 1'b0; end
    end
  endtask

  task automatic test_coincident();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (k == 0)       e = mk(8'h00, 2'd3, 1'b0, 1'b0);
      else if (k <= 4)  e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      else if (k <= 8)  e = mk(8'h19, 2'd1, 1'b0, 1'b0);
      else if (k <= 12) e = mk(8'h1E, 2'd2, 1'b0, 1'b0);
      else              e = mk(8'h0A, 2'd0, 1'b0, 1'b0);
      sb_q.push_back(e);
    end
    nsr_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      o = {led_out, field_id, alert_ack, stale};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL coincident k=%0d: got led=%02h fid=%0d ack=%0b stale=%0b expected led=%02h fid=%0d ack=%0b stale=%0b",
                 k, o.led, o.fid, o.ack, o.stl, e.led, e.fid, e.ack, e.stl);
      end
      if (k == 0) nsr_valid = 1'b0;
      if (k == 7) begin nsr_valid = 1'b1; gps_sec = 6'd30; end
      if (k == 8) nsr_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_manual();
    test_alert();
    test_back_to_back();
    test_stale();
    test_reset_alert();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
